vote_entry_fsm: RTL and testbench
=================================

# vote_entry_fsm

Voter-input controller for the ballot box, directly upstream of the per-candidate BCD tally counters. It turns raw keypad and button activity into a two-digit candidate code, holds it for review, and on confirmation emits exactly one single-cycle count pulse. That pulse goes to the matching candidate counter, or to the blank or null counter, plus the total-votes counter. After each vote it enforces a lockout so one press cannot register two votes.

## Interface
- NUM_CAND, 4: number of valid candidates, codes 01..NUM_CAND; legal range 1..9.
- LOCK_CYCLES, 50000000: length of the post-vote lockout in clock cycles; must be ≥ 2.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high.
- session_open  input  1  asynchronous level; high while polling is open.
- key_digit  input  4  BCD digit on the keypad; sampled on the key_press event.
- key_press  input  1  asynchronous, already debounced; a rising edge is one digit entry.
- confirm_btn  input  1  asynchronous, debounced; a rising edge is "confirm".
- correct_btn  input  1  asynchronous, debounced; a rising edge is "correct" (clear entry).
- blank_btn  input  1  asynchronous, debounced; a rising edge is "blank vote".
- vote_pulse  output  NUM_CAND  one-hot; bit i-1 pulses for candidate code i.
- blank_pulse  output  1  one-cycle pulse for a blank vote.
- null_pulse  output  1  one-cycle pulse for a null vote (invalid code).
- total_pulse  output  1  one-cycle pulse on every registered vote.
- digit_hi, digit_lo  output  4 each  entered digits, for display.
- show_hi, show_lo  output  1 each  the corresponding digit has been entered.
- is_blank  output  1  the entry under review is a blank vote.
- busy  output  1  high during lockout.
- state  output  3  CLOSED=0, IDLE=1, DIGIT1=2, REVIEW=3, LOCK=4.

## Operation
- Each asynchronous input passes through a 2-FF synchronizer. Each button then goes through a rising-edge detector, which yields one-cycle events. session_open is used as a synchronized level.
- Events in the same cycle are prioritized correct > confirm > blank > digit. Only the highest-priority applicable event is acted on; the others are dropped.
- A digit event with key_digit > 9 is ignored.
- CLOSED: all entry cleared. Moves to IDLE when session_open is high.
- IDLE:
  - A digit event stores the digit in digit_hi, sets show_hi, and moves to DIGIT1.
  - A blank event sets is_blank and moves to REVIEW.
  - Confirm and correct are ignored.
- DIGIT1:
  - A digit event stores the digit in digit_lo, sets show_lo, and moves to REVIEW.
  - A correct event clears the entry and moves to IDLE.
  - Confirm and blank are ignored.
- REVIEW:
  - Digit and blank events are ignored.
  - A correct event clears the entry and moves to IDLE.
  - A confirm event classifies the entry and moves to LOCK:
    - is_blank: blank_pulse.
    - code 10·digit_hi+digit_lo = 00: blank_pulse.
    - code in 01..NUM_CAND: vote_pulse[code-1].
    - any other code: null_pulse.
  - total_pulse fires in every case.
  - The entry is cleared on the same edge.
- LOCK:
  - busy=1; all button events are discarded, not queued.
  - The counter loads LOCK_CYCLES-1 on entry and decrements each cycle.
  - At zero, the next edge moves to IDLE.
- Closing the session: synchronized session_open low forces CLOSED from any state on the next edge and clears the entry and lock counter. A pulse already issued is not retracted.
- Reset: state=CLOSED. All pulses, digits, show_hi, show_lo, is_blank and busy are 0. Synchronizer and edge-detect registers are 0, so a button held high through reset produces one event after release of reset.
- Exactly one of vote_pulse/blank_pulse/null_pulse is high when total_pulse is high, and never otherwise.

## Timing
- An input rising edge captured by sync FF1 at edge n is acted on at edge n+2. State and display outputs change after edge n+2.
- All outputs are registered. A vote pulse is high for exactly the one cycle following edge n+2 of the confirm.
- busy rises on the same edge as the pulses, stays high LOCK_CYCLES cycles, and falls on the edge that enters IDLE.
- A new key event can be accepted at the first edge after entering IDLE.
- session_open falling: state=CLOSED after 2 synchronizer edges plus 1 edge.

## Test plan
- Entry of the three digits 1, 3, 4 with NUM_CAND=4 handles each code separately:
  - key 1, key 3, confirm: null_pulse and total_pulse high for 1 cycle (code 13 > 4); busy high for LOCK_CYCLES cycles, then state=IDLE.
  - key 0, key 4, confirm: vote_pulse=4'b1000 and total_pulse for 1 cycle; digits cleared.
- Blank button in IDLE then confirm -> blank_pulse + total_pulse. Key 0, key 0, confirm -> blank_pulse.
- Key 2, correct, key 0, key 1, confirm -> only vote_pulse[0]; correct and confirm asserted in the same cycle in REVIEW -> IDLE, no pulse.
- Confirm pressed 10 times during LOCK (LOCK_CYCLES=8 for sim) -> no extra pulses; key 10 (0xA) in IDLE -> ignored, show_hi stays 0.
- Drop session_open in REVIEW -> CLOSED within 3 edges, no pulse; assert reset mid-LOCK -> all outputs 0 immediately, state=CLOSED.

Source files
------------

// File: rtl/vote_entry_fsm.sv
// Ballot-box voter entry controller.
// Synchronizes keypad and buttons, assembles a two-digit candidate code, holds it
// for review and, on confirm, issues exactly one classified count pulse plus a
// total pulse, followed by a lockout window that discards all button activity.
module vote_entry_fsm #(
    parameter int unsigned NUM_CAND    = 4,
    parameter int unsigned LOCK_CYCLES = 50000000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                session_open,
    input  logic [3:0]          key_digit,
    input  logic                key_press,
    input  logic                confirm_btn,
    input  logic                correct_btn,
    input  logic                blank_btn,
    output logic [NUM_CAND-1:0] vote_pulse,
    output logic                blank_pulse,
    output logic                null_pulse,
    output logic                total_pulse,
    output logic [3:0]          digit_hi,
    output logic [3:0]          digit_lo,
    output logic                show_hi,
    output logic                show_lo,
    output logic                is_blank,
    output logic                busy,
    output logic [2:0]          state
);

    // Lock counter holds LOCK_CYCLES-1 down to 0; code covers 00..99.
    localparam int unsigned CNT_W     = $clog2(LOCK_CYCLES);
    localparam int unsigned CODE_W    = 7;
    localparam int unsigned DIGIT_W   = 4;
    localparam int unsigned BTN_W     = 4;
    localparam int unsigned B_KEY     = 0;
    localparam int unsigned B_CONFIRM = 1;
    localparam int unsigned B_CORRECT = 2;
    localparam int unsigned B_BLANK   = 3;

    typedef enum logic [2:0] {
        ST_CLOSED = 3'd0,
        ST_IDLE   = 3'd1,
        ST_DIGIT1 = 3'd2,
        ST_REVIEW = 3'd3,
        ST_LOCK   = 3'd4
    } state_t;

    // Synchronizer and edge-detect storage.
    logic                 sess_s1;
    logic                 sess_s2;
    logic [BTN_W-1:0]     btn_s1;
    logic [BTN_W-1:0]     btn_s2;
    logic [BTN_W-1:0]     btn_prev;
    logic [DIGIT_W-1:0]   digit_s1;
    logic [DIGIT_W-1:0]   digit_s2;

    // Decoded single-cycle events and helpers.
    logic [BTN_W-1:0]     ev_c;
    logic                 digit_ok_c;
    logic [CODE_W-1:0]    code_c;

    // FSM register and next-state / next-output values.
    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [NUM_CAND-1:0]  vote_d;
    logic                 blank_d;
    logic                 null_d;
    logic                 total_d;
    logic [DIGIT_W-1:0]   digit_hi_d;
    logic [DIGIT_W-1:0]   digit_lo_d;
    logic                 show_hi_d;
    logic                 show_lo_d;
    logic                 is_blank_d;
    logic                 busy_d;
    logic                 clear_entry;

    // Two-flop synchronizers for every asynchronous input, plus edge-detect history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sess_s1  <= 1'b0;
            sess_s2  <= 1'b0;
            btn_s1   <= '0;
            btn_s2   <= '0;
            btn_prev <= '0;
            digit_s1 <= '0;
            digit_s2 <= '0;
        end else begin
            sess_s1  <= session_open;
            sess_s2  <= sess_s1;
            btn_s1   <= {blank_btn, correct_btn, confirm_btn, key_press};
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
            digit_s1 <= key_digit;
            digit_s2 <= digit_s1;
        end
    end

    // Rising-edge events, digit validity and the two-digit code under review.
    assign ev_c       = btn_s2 & ~btn_prev;
    assign digit_ok_c = (digit_s2 <= 4'd9);
    assign code_c     = CODE_W'(digit_hi) * CODE_W'(10) + CODE_W'(digit_lo);

    // Next-state, next-output and lock counter decisions.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vote_d      = '0;
        blank_d     = 1'b0;
        null_d      = 1'b0;
        total_d     = 1'b0;
        digit_hi_d  = digit_hi;
        digit_lo_d  = digit_lo;
        show_hi_d   = show_hi;
        show_lo_d   = show_lo;
        is_blank_d  = is_blank;
        clear_entry = 1'b0;

        if (!sess_s2) begin
            // Closing the session overrides everything, including a pending confirm.
            state_d     = ST_CLOSED;
            cnt_d       = '0;
            clear_entry = 1'b1;
        end else begin
            case (state_q)
                ST_CLOSED: begin
                    state_d     = ST_IDLE;
                    clear_entry = 1'b1;
                end
                ST_IDLE: begin
                    if (ev_c[B_BLANK]) begin
                        is_blank_d = 1'b1;
                        state_d    = ST_REVIEW;
                    end else if (ev_c[B_KEY] && digit_ok_c) begin
                        digit_hi_d = digit_s2;
                        show_hi_d  = 1'b1;
                        state_d    = ST_DIGIT1;
                    end
                end
                ST_DIGIT1: begin
                    if (ev_c[B_CORRECT]) begin
                        clear_entry = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (ev_c[B_KEY] && digit_ok_c) begin
                        digit_lo_d = digit_s2;
                        show_lo_d  = 1'b1;
                        state_d    = ST_REVIEW;
                    end
                end
                ST_REVIEW: begin
                    if (ev_c[B_CORRECT]) begin
                        clear_entry = 1'b1;
                        state_d     = ST_IDLE;
                    end else if (ev_c[B_CONFIRM]) begin
                        // Classify: blank flag or code 00 is blank, 1..NUM_CAND a candidate.
                        if (is_blank || (code_c == '0)) begin
                            blank_d = 1'b1;
                        end else if (code_c > CODE_W'(NUM_CAND)) begin
                            null_d = 1'b1;
                        end else begin
                            for (int unsigned i = 0; i < NUM_CAND; i++) begin
                                if (code_c == CODE_W'(i + 1)) begin
                                    vote_d[i] = 1'b1;
                                end
                            end
                        end
                        total_d     = 1'b1;
                        clear_entry = 1'b1;
                        cnt_d       = CNT_W'(LOCK_CYCLES - 1);
                        state_d     = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // Events are simply not looked at here, so nothing queues up.
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d     = ST_CLOSED;
                    cnt_d       = '0;
                    clear_entry = 1'b1;
                end
            endcase
        end

        if (clear_entry) begin
            digit_hi_d = '0;
            digit_lo_d = '0;
            show_hi_d  = 1'b0;
            show_lo_d  = 1'b0;
            is_blank_d = 1'b0;
        end

        busy_d = (state_d == ST_LOCK);
    end

    // State, lock counter and all registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CLOSED;
            cnt_q       <= '0;
            vote_pulse  <= '0;
            blank_pulse <= 1'b0;
            null_pulse  <= 1'b0;
            total_pulse <= 1'b0;
            digit_hi    <= '0;
            digit_lo    <= '0;
            show_hi     <= 1'b0;
            show_lo     <= 1'b0;
            is_blank    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vote_pulse  <= vote_d;
            blank_pulse <= blank_d;
            null_pulse  <= null_d;
            total_pulse <= total_d;
            digit_hi    <= digit_hi_d;
            digit_lo    <= digit_lo_d;
            show_hi     <= show_hi_d;
            show_lo     <= show_lo_d;
            is_blank    <= is_blank_d;
            busy        <= busy_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_vote_entry_fsm.sv
// Self-checking bench for vote_entry_fsm: a per-cycle behavioural model of the
// entry/vote/lock rules plus directed scenarios with literal expectations.
module tb_vote_entry_fsm;

    localparam int unsigned NUM_CAND    = 4;
    localparam int unsigned LOCK_CYCLES = 8;
    localparam int unsigned M_KEY       = 1;
    localparam int unsigned M_CONF      = 2;
    localparam int unsigned M_CORR      = 4;
    localparam int unsigned M_BLANK     = 8;

    logic                clock        = 1'b0;
    logic                reset        = 1'b1;
    logic                session_open = 1'b0;
    logic [3:0]          key_digit    = 4'd0;
    logic                key_press    = 1'b0;
    logic                confirm_btn  = 1'b0;
    logic                correct_btn  = 1'b0;
    logic                blank_btn    = 1'b0;
    logic [NUM_CAND-1:0] vote_pulse;
    logic                blank_pulse;
    logic                null_pulse;
    logic                total_pulse;
    logic [3:0]          digit_hi;
    logic [3:0]          digit_lo;
    logic                show_hi;
    logic                show_lo;
    logic                is_blank;
    logic                busy;
    logic [2:0]          state;

    int n_checks = 0;
    int n_pass   = 0;

    vote_entry_fsm #(
        .NUM_CAND   (NUM_CAND),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .session_open(session_open),
        .key_digit   (key_digit),
        .key_press   (key_press),
        .confirm_btn (confirm_btn),
        .correct_btn (correct_btn),
        .blank_btn   (blank_btn),
        .vote_pulse  (vote_pulse),
        .blank_pulse (blank_pulse),
        .null_pulse  (null_pulse),
        .total_pulse (total_pulse),
        .digit_hi    (digit_hi),
        .digit_lo    (digit_lo),
        .show_hi     (show_hi),
        .show_lo     (show_lo),
        .is_blank    (is_blank),
        .busy        (busy),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    // Raw input samples at recent edges: bit k is the sample taken k edges ago.
    logic [3:0] h_key   = 4'd0;
    logic [3:0] h_conf  = 4'd0;
    logic [3:0] h_corr  = 4'd0;
    logic [3:0] h_blank = 4'd0;
    logic [3:0] h_sess  = 4'd0;
    logic [3:0] h_dig [4] = '{default: 4'd0};

    bit                  m_open  = 1'b0;
    int                  m_dig[$];
    bit                  m_blank = 1'b0;
    int                  m_lock  = 0;
    logic [NUM_CAND-1:0] e_vote  = '0;
    bit                  e_blank = 1'b0;
    bit                  e_null  = 1'b0;
    bit                  e_total = 1'b0;

    task automatic model_clear();
        m_dig.delete();
        m_blank = 1'b0;
    endtask

    task automatic model_step();
        bit ek, ecf, ecr, ebl;
        int d, code;
        if (reset) begin
            h_key = 0; h_conf = 0; h_corr = 0; h_blank = 0; h_sess = 0;
            for (int k = 0; k < 4; k++) h_dig[k] = 4'd0;
            m_open = 1'b0; m_lock = 0; model_clear();
            e_vote = '0; e_blank = 0; e_null = 0; e_total = 0;
            return;
        end
        h_key   = {h_key[2:0], key_press};
        h_conf  = {h_conf[2:0], confirm_btn};
        h_corr  = {h_corr[2:0], correct_btn};
        h_blank = {h_blank[2:0], blank_btn};
        h_sess  = {h_sess[2:0], session_open};
        for (int k = 3; k > 0; k--) h_dig[k] = h_dig[k-1];
        h_dig[0] = key_digit;
        // A raw rising edge sampled two edges ago is acted on now.
        ek  = h_key[2]   & ~h_key[3];
        ecf = h_conf[2]  & ~h_conf[3];
        ecr = h_corr[2]  & ~h_corr[3];
        ebl = h_blank[2] & ~h_blank[3];
        d   = int'(h_dig[2]);
        e_vote = '0; e_blank = 0; e_null = 0; e_total = 0;
        if (!h_sess[2]) begin
            m_open = 1'b0; m_lock = 0; model_clear();
        end else if (!m_open) begin
            m_open = 1'b1;
        end else if (m_lock > 0) begin
            m_lock--;
        end else if (m_blank || m_dig.size() == 2) begin
            if (ecr) model_clear();
            else if (ecf) begin
                code = m_blank ? 0 : 10 * m_dig[0] + m_dig[1];
                if (code == 0) e_blank = 1'b1;
                else if (code <= int'(NUM_CAND)) e_vote[code-1] = 1'b1;
                else e_null = 1'b1;
                e_total = 1'b1;
                model_clear();
                m_lock = LOCK_CYCLES;
            end
        end else if (m_dig.size() == 1) begin
            if (ecr) model_clear();
            else if (ek && d <= 9) m_dig.push_back(d);
        end else begin
            if (ebl) m_blank = 1'b1;
            else if (ek && d <= 9) m_dig.push_back(d);
        end
    endtask

    function automatic logic [2:0] exp_state();
        if (!m_open) return 3'd0;
        if (m_lock > 0) return 3'd4;
        if (m_blank || m_dig.size() == 2) return 3'd3;
        if (m_dig.size() == 1) return 3'd2;
        return 3'd1;
    endfunction

    // Model advances on every clock edge and immediately on reset assertion.
    initial forever begin
        @(posedge clock or posedge reset);
        model_step();
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge clock);
        check("cyc_state",    32'(state),       32'(exp_state()));
        check("cyc_vote",     32'(vote_pulse),  32'(e_vote));
        check("cyc_blankp",   32'(blank_pulse), 32'(e_blank));
        check("cyc_nullp",    32'(null_pulse),  32'(e_null));
        check("cyc_total",    32'(total_pulse), 32'(e_total));
        check("cyc_digit_hi", 32'(digit_hi),    32'((m_dig.size() >= 1) ? m_dig[0] : 0));
        check("cyc_digit_lo", 32'(digit_lo),    32'((m_dig.size() >= 2) ? m_dig[1] : 0));
        check("cyc_show_hi",  32'(show_hi),     32'(m_dig.size() >= 1));
        check("cyc_show_lo",  32'(show_lo),     32'(m_dig.size() >= 2));
        check("cyc_is_blank", 32'(is_blank),    32'(m_blank));
        check("cyc_busy",     32'(busy),        32'(m_lock > 0));
    end

    // Capture the most recent vote pulse and count busy cycles for literal checks.
    int                  pulse_cnt = 0;
    int                  busy_cnt  = 0;
    logic [NUM_CAND-1:0] cap_vote  = '0;
    logic                cap_blank = 1'b0;
    logic                cap_null  = 1'b0;
    logic                cap_show  = 1'b0;
    initial forever begin
        @(negedge clock);
        if (total_pulse) begin
            pulse_cnt++;
            cap_vote  = vote_pulse;
            cap_blank = blank_pulse;
            cap_null  = null_pulse;
            cap_show  = show_hi;
        end
        if (busy) busy_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input int unsigned mask, input logic [3:0] d);
        @(negedge clock);
        key_digit = d;
        @(negedge clock);
        key_press   = mask[0];
        confirm_btn = mask[1];
        correct_btn = mask[2];
        blank_btn   = mask[3];
        repeat (2) @(negedge clock);
        key_press = 0; confirm_btn = 0; correct_btn = 0; blank_btn = 0;
        repeat (4) @(negedge clock);
    endtask

    task automatic wait_idle(input string name);
        int i = 0;
        while (state != 3'd1 && i < 40) begin
            @(negedge clock);
            i++;
        end
        check({name, "_idle"}, 32'(state), 32'd1);
    endtask

    task automatic check_vote(input string name, input int p0,
                              input logic [3:0] v, input logic b, input logic n);
        check({name, "_npulse"}, 32'(pulse_cnt - p0), 32'd1);
        check({name, "_vote"},   32'(cap_vote),        32'(v));
        check({name, "_blank"},  32'(cap_blank),       32'(b));
        check({name, "_null"},   32'(cap_null),        32'(n));
        check({name, "_clear"},  32'(cap_show),        32'd0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int p0;
        repeat (3) @(negedge clock);
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_vote",  32'(vote_pulse), 32'd0);
        check("rst_show",  32'({show_hi, show_lo, is_blank}), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("closed_wo_session", 32'(state), 32'd0);

        session_open = 1'b1;
        wait_idle("open");

        // Out-of-range digit is ignored.
        press(M_KEY, 4'hA);
        check("key_a_show", 32'(show_hi), 32'd0);
        check("key_a_state", 32'(state), 32'd1);

        // Code 13 with four candidates is a null vote.
        press(M_KEY, 4'd1);
        check("k1_digit_hi", 32'(digit_hi), 32'd1);
        check("k1_state",    32'(state), 32'd2);
        press(M_KEY, 4'd3);
        check("k3_digit_lo", 32'(digit_lo), 32'd3);
        check("k3_state",    32'(state), 32'd3);
        busy_cnt = 0;
        p0 = pulse_cnt;
        press(M_CONF, 4'd0);
        check_vote("c13", p0, 4'b0000, 1'b0, 1'b1);
        wait_idle("c13");
        check("c13_busy_len", 32'(busy_cnt), 32'(LOCK_CYCLES));

        // Code 04 goes to candidate 4.
        press(M_KEY, 4'd0);
        press(M_KEY, 4'd4);
        p0 = pulse_cnt;
        press(M_CONF, 4'd0);
        check_vote("c04", p0, 4'b1000, 1'b0, 1'b0);
        wait_idle("c04");

        // Blank button then confirm.
        press(M_BLANK, 4'd0);
        check("blank_flag",  32'(is_blank), 32'd1);
        check("blank_state", 32'(state), 32'd3);
        p0 = pulse_cnt;
        press(M_CONF, 4'd0);
        check_vote("cblank", p0, 4'b0000, 1'b1, 1'b0);
        wait_idle("cblank");

        // Code 00 counts as blank.
        press(M_KEY, 4'd0);
        press(M_KEY, 4'd0);
        p0 = pulse_cnt;
        press(M_CONF, 4'd0);
        check_vote("c00", p0, 4'b0000, 1'b1, 1'b0);
        wait_idle("c00");

        // Correct after one digit, then code 01.
        press(M_KEY, 4'd2);
        press(M_CORR, 4'd0);
        check("corr_state", 32'(state), 32'd1);
        check("corr_show",  32'(show_hi), 32'd0);
        press(M_KEY, 4'd0);
        press(M_KEY, 4'd1);
        p0 = pulse_cnt;
        press(M_CONF, 4'd0);
        check_vote("c01", p0, 4'b0001, 1'b0, 1'b0);
        wait_idle("c01");

        // Correct and confirm together in review: correct wins, no pulse.
        press(M_KEY, 4'd1);
        press(M_KEY, 4'd2);
        p0 = pulse_cnt;
        press(M_CONF | M_CORR, 4'd0);
        check("cc_state",  32'(state), 32'd1);
        check("cc_npulse", 32'(pulse_cnt - p0), 32'd0);
        check("cc_busy",   32'(busy), 32'd0);

        // Code 03, then a key and ten confirms during/after lockout: nothing extra.
        press(M_KEY, 4'd0);
        press(M_KEY, 4'd3);
        p0 = pulse_cnt;
        @(negedge clock);
        confirm_btn = 1'b1;
        key_digit   = 4'd2;
        repeat (2) @(negedge clock);
        confirm_btn = 1'b0;
        @(negedge clock);
        key_press = 1'b1;
        repeat (2) @(negedge clock);
        key_press = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            confirm_btn = 1'b1;
            @(negedge clock);
            confirm_btn = 1'b0;
        end
        repeat (4) @(negedge clock);
        wait_idle("lockspam");
        check("lockspam_npulse", 32'(pulse_cnt - p0), 32'd1);
        check("lockspam_vote",   32'(cap_vote), 32'b0100);
        check("lockspam_show",   32'(show_hi), 32'd0);

        // Session closes during review: CLOSED three edges later, no pulse.
        press(M_KEY, 4'd4);
        press(M_KEY, 4'd1);
        check("close_pre", 32'(state), 32'd3);
        p0 = pulse_cnt;
        @(negedge clock);
        session_open = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("close_state",  32'(state), 32'd0);
        check("close_npulse", 32'(pulse_cnt - p0), 32'd0);
        check("close_show",   32'({show_hi, show_lo}), 32'd0);
        session_open = 1'b1;
        wait_idle("reopen");

        // Reset asserted mid-lockout clears everything immediately.
        press(M_KEY, 4'd0);
        press(M_KEY, 4'd2);
        p0 = pulse_cnt;
        press(M_CONF, 4'd0);
        check_vote("c02", p0, 4'b0010, 1'b0, 1'b0);
        check("c02_lock", 32'(state), 32'd4);
        check("c02_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_pulse", 32'({vote_pulse, blank_pulse, null_pulse, total_pulse}), 32'd0);
        check("mid_rst_disp",  32'({digit_hi, digit_lo, show_hi, show_lo, is_blank}), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
